regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with a built-in pending-write scoreboard, the next generation of the pipeline's three-port register bank. It provides NUM_RD combinational read ports and two synchronous write ports: EX/ALU writeback on port A, MEM/load writeback on port B. Same-cycle write-to-read bypass is selectable. It tracks which destination registers have an in-flight write and raises a stall to the decode stage on RAW/WAW hazards. The PC index reads the externally supplied PC+8 value and is never stored.

## Interface
- DATA_W, 32, register width
- ADDR_W, 4, register index width; DEPTH = 2**ADDR_W
- NUM_RD, 3, number of read ports
- PC_IDX, 2**ADDR_W-1, index that reads pc_val instead of storage
- BYPASS, 1, 1 = same-cycle writeback data forwarded to reads and hazard check
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low
- ra  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  read data, same packing
- pc_val  in  DATA_W  value returned for PC_IDX (PC+8)
- we_a, wa_a, wd_a  in  1/ADDR_W/DATA_W  ALU writeback port
- we_b, wa_b, wd_b  in  1/ADDR_W/DATA_W  load writeback port
- iss_valid  in  1  decode presents an instruction
- iss_src  in  NUM_RD*ADDR_W  source indices to hazard-check
- iss_src_v  in  NUM_RD  per-source valid
- iss_dst, iss_dst_v  in  ADDR_W/1  destination index and valid
- stall  out  1  issue blocked this cycle (combinational)
- busy  out  DEPTH  pending-write vector (registered)

## Operation
- Storage: DEPTH-1 entries of DATA_W. Reset low on a clock edge sets all entries to 0 and busy to 0. Reset has priority over writes and issue.
- Writes: on the rising edge, if we_x is set and wa_x != PC_IDX, store wd_x. Writes addressed to PC_IDX are dropped. If both ports target the same address, port B wins.
- Reads: rd[i] = pc_val if ra[i] == PC_IDX. Otherwise, with BYPASS=1, a matching active write port supplies the data (B before A). Otherwise rd[i] = storage.
- Clear set: clr = {wa_a if we_a} ∪ {wa_b if we_b}. Writebacks to non-busy registers still write and leave busy unchanged.
- Hazard: src_haz = some valid source s with s != PC_IDX, busy[s] = 1, and (BYPASS=0 or s ∉ clr).
- dst_haz = iss_dst_v, iss_dst != PC_IDX, busy[iss_dst] = 1 and iss_dst ∉ clr. This blocks WAW, so busy needs no counter.
- stall = iss_valid & (src_haz | dst_haz).
- Issue accepted when iss_valid & !stall. If iss_dst_v and iss_dst != PC_IDX, busy[iss_dst] is set next edge.
- Busy update per edge: bits in clr are cleared, then the accepted dst bit is set. If both apply to one bit, set wins.
- busy[PC_IDX] is always 0.

## Timing
- Reads and stall: combinational, zero latency.
- Writes and busy: one-edge latency. A value written at edge n is visible from storage after n. With BYPASS=1 it is also visible in the cycle before n.
- Reset values: busy = 0, stall = 0 while iss_valid = 0. rd = 0 for non-PC indices with no active bypass.
- Reset asserted while busy bits are set: all bits clear on that edge, and writebacks arriving in the same edge are discarded.
- Reset deasserted: normal operation from the next edge.

## Structure
- Package regfile_pkg:
  - DATA_W/ADDR_W defaults
  - typedef reg_idx_t
  - typedef wb_port_t struct {we, wa, wd}
  - function in_clr(idx, wb_a, wb_b)
- Sub-module regfile_scoreboard: the busy vector, clr decode and stall logic. The top level holds storage, read muxing and bypass.

## Test plan
- Reset low one edge after writes to r1..r3 (r1=0xDEAD) -> every rd = 0, busy = 0. ra=15 with pc_val=0x108 -> rd = 0x108.
- we_a, wa_a=2, wd_a=0x11 plus we_b, wa_b=2, wd_b=0x22 in the same cycle, ra0=2 -> same-cycle rd0 = 0x22 (BYPASS=1) or old value (BYPASS=0). rd0 = 0x22 after the edge.
- Issue dst=5 accepted -> busy[5] = 1 next cycle. Issue src0=5 -> stall = 1 until the cycle we_b, wa_b=5 arrives. There stall = 0 with BYPASS=1, or stall = 1 with BYPASS=0 and clears one cycle later.
- Issue dst=5 while busy[5] = 1 and no clear -> stall = 1. Same issue in the cycle wa_a=5 writes back -> accepted, busy[5] stays 1 (set wins).
- we_a, wa_a=15, wd_a=0xFF -> storage unchanged, rd for 15 = pc_val. Issue dst=15 -> busy unaffected, stall = 0.
- busy = 0x0036 then reset low on the same edge as we_a, wa_a=1 -> busy = 0 and r1 = 0 after the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types for the register file with pending-write scoreboard.
//   RF_DATA_W / RF_ADDR_W : default register width and index width
//   reg_idx_t             : register index
//   wb_port_t             : one writeback port {we, wa, wd}
//   in_clr()              : true when a writeback port targets idx this cycle
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 4;

    typedef logic [RF_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        logic                 we;
        reg_idx_t             wa;
        logic [RF_DATA_W-1:0] wd;
    } wb_port_t;

    // An index is in the clear set when either active writeback port targets it.
    function automatic logic in_clr(input reg_idx_t idx, input wb_port_t a, input wb_port_t b);
        return (a.we && (a.wa == idx)) || (b.we && (b.wa == idx));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Pending-write tracker. Holds one busy bit per register, clears bits as
// writebacks land and sets the destination bit of each accepted issue.
// Raises stall on RAW (busy source) and WAW (busy destination) hazards.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   we_a/wa_a, we_b/wa_b       writeback enables and indices (clear set)
//   iss_valid                  decode presents an instruction
//   iss_src, iss_src_v         packed source indices and per-source valid
//   iss_dst, iss_dst_v         destination index and valid
//   stall                      combinational issue block
//   busy                       registered pending-write vector
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = 3,
    parameter int PC_IDX = 2**ADDR_W - 1,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_a,
    input  logic [ADDR_W-1:0]        wa_a,
    input  logic                     we_b,
    input  logic [ADDR_W-1:0]        wa_b,
    input  logic                     iss_valid,
    input  logic [NUM_RD*ADDR_W-1:0] iss_src,
    input  logic [NUM_RD-1:0]        iss_src_v,
    input  logic [ADDR_W-1:0]        iss_dst,
    input  logic                     iss_dst_v,
    output logic                     stall,
    output logic [2**ADDR_W-1:0]     busy
);

    localparam int                DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_IDX);
    localparam bit                BYP   = (BYPASS != 0);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_busy_nxt;
    logic             w_src_haz;
    logic             w_dst_haz;
    logic             w_set_dst;

    // Decoded clear set: one bit per register written back this cycle.
    always_comb begin
        w_clr = '0;
        for (int d = 0; d < DEPTH; d++) begin
            w_clr[d] = in_clr(reg_idx_t'(d),
                              wb_port_t'{we: we_a, wa: wa_a, wd: '0},
                              wb_port_t'{we: we_b, wa: wa_b, wd: '0});
        end
    end

    // A source landing this cycle is only safe when its data is forwarded.
    // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_src_haz = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (iss_src_v[i]
                && (iss_src[i*ADDR_W +: ADDR_W] != PC_A)
                && r_busy[iss_src[i*ADDR_W +: ADDR_W]]
                && (!BYP || !w_clr[iss_src[i*ADDR_W +: ADDR_W]])) begin
                w_src_haz = 1'b1;
            end
        end
    end

    // Blocking a second writer to a busy register keeps busy a single bit.
    assign w_dst_haz = iss_dst_v && (iss_dst != PC_A) && r_busy[iss_dst] && !w_clr[iss_dst];
    assign stall     = iss_valid && (w_src_haz || w_dst_haz);
    assign w_set_dst = iss_valid && !stall && iss_dst_v && (iss_dst != PC_A);

    // Clear first, then set, so a same-edge issue to a landing register wins.
    always_comb begin
        w_busy_nxt = r_busy & ~w_clr;
        if (w_set_dst) begin
            w_busy_nxt[iss_dst] = 1'b1;
        end
        w_busy_nxt[PC_A] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Register file with NUM_RD combinational read ports, two synchronous write
// ports (A = ALU writeback, B = load writeback, B wins on conflict), optional
// same-cycle write-to-read bypass and a pending-write scoreboard. Index PC_IDX
// reads pc_val and is never stored.
// Ports:
//   clk, reset               clock, synchronous active-low reset
//   ra / rd                  packed read addresses / read data
//   pc_val                   value returned for PC_IDX
//   we_a, wa_a, wd_a         ALU writeback port
//   we_b, wa_b, wd_b         load writeback port
//   iss_*                    decode issue request for hazard checking
//   stall                    issue blocked this cycle
//   busy                     pending-write vector
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = 3,
    parameter int PC_IDX = 2**ADDR_W - 1,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic [DATA_W-1:0]        pc_val,
    input  logic                     we_a,
    input  logic [ADDR_W-1:0]        wa_a,
    input  logic [DATA_W-1:0]        wd_a,
    input  logic                     we_b,
    input  logic [ADDR_W-1:0]        wa_b,
    input  logic [DATA_W-1:0]        wd_b,
    input  logic                     iss_valid,
    input  logic [NUM_RD*ADDR_W-1:0] iss_src,
    input  logic [NUM_RD-1:0]        iss_src_v,
    input  logic [ADDR_W-1:0]        iss_dst,
    input  logic                     iss_dst_v,
    output logic                     stall,
    output logic [2**ADDR_W-1:0]     busy
);

    localparam int                DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_IDX);
    localparam bit                BYP   = (BYPASS != 0);

    wb_port_t w_wb_a;
    wb_port_t w_wb_b;

    // The PC slot is never written, so it stays constant zero and is trimmed.
    logic [DATA_W-1:0] r_mem [DEPTH];

    assign w_wb_a = '{we: we_a, wa: wa_a, wd: wd_a};
    assign w_wb_b = '{we: we_b, wa: wa_b, wd: wd_b};

    // Port B is written last so it wins when both ports hit one address.
    // NOTE: the storage array is reset explicitly because reads of never-written registers must return 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                r_mem[d] <= '0;
            end
        end else begin
            if (w_wb_a.we && (w_wb_a.wa != PC_A)) begin
                r_mem[w_wb_a.wa] <= w_wb_a.wd;
            end
            if (w_wb_b.we && (w_wb_b.wa != PC_A)) begin
                r_mem[w_wb_b.wa] <= w_wb_b.wd;
            end
        end
    end

    // Read priority: PC index, then bypass from B, then from A, then storage.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = ra[g*ADDR_W +: ADDR_W];
        assign rd[g*DATA_W +: DATA_W] =
            (w_ra == PC_A)                             ? pc_val   :
            (BYP && w_wb_b.we && (w_wb_b.wa == w_ra))  ? w_wb_b.wd :
            (BYP && w_wb_a.we && (w_wb_a.wa == w_ra))  ? w_wb_a.wd :
                                                         r_mem[w_ra];
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .PC_IDX (PC_IDX),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .we_a      (we_a),
        .wa_a      (wa_a),
        .we_b      (we_b),
        .wa_b      (wa_b),
        .iss_valid (iss_valid),
        .iss_src   (iss_src),
        .iss_src_v (iss_src_v),
        .iss_dst   (iss_dst),
        .iss_dst_v (iss_dst_v),
        .stall     (stall),
        .busy      (busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Self-checking bench for regfile_sb. Two instances share all inputs: one with
// bypass enabled, one without. Read/write behaviour is driven from a table of
// hand-computed vectors; hazard, WAW, PC-index and reset corner cases are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic [11:0] ra;
    logic [95:0] rd_byp;
    logic [95:0] rd_nb;
    logic [31:0] pc_val;
    logic        we_a;
    logic [3:0]  wa_a;
    logic [31:0] wd_a;
    logic        we_b;
    logic [3:0]  wa_b;
    logic [31:0] wd_b;
    logic        iss_valid;
    logic [11:0] iss_src;
    logic [2:0]  iss_src_v;
    logic [3:0]  iss_dst;
    logic        iss_dst_v;
    logic        stall_byp;
    logic        stall_nb;
    logic [15:0] busy_byp;
    logic [15:0] busy_nb;

    int n_vec;
    int n_err;

    typedef struct {
        logic        we_a;
        logic [3:0]  wa_a;
        logic [31:0] wd_a;
        logic        we_b;
        logic [3:0]  wa_b;
        logic [31:0] wd_b;
        logic [11:0] ra;
        logic [95:0] exp_byp;
        logic [95:0] exp_nb;
    } vec_t;

    vec_t vecs [7];

    regfile_sb #(.BYPASS(1)) dut_byp (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_byp), .pc_val(pc_val),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .iss_valid(iss_valid), .iss_src(iss_src), .iss_src_v(iss_src_v),
        .iss_dst(iss_dst), .iss_dst_v(iss_dst_v), .stall(stall_byp), .busy(busy_byp)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_nb), .pc_val(pc_val),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .iss_valid(iss_valid), .iss_src(iss_src), .iss_src_v(iss_src_v),
        .iss_dst(iss_dst), .iss_dst_v(iss_dst_v), .stall(stall_nb), .busy(busy_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        iss_valid = 1'b0; iss_src = '0; iss_src_v = '0;
        iss_dst = '0; iss_dst_v = 1'b0;
    endtask

    task automatic issue(input logic [3:0] src0, input logic src0_v,
                         input logic [3:0] dst, input logic dst_v);
        iss_valid = 1'b1;
        iss_src   = {8'h00, src0};
        iss_src_v = {2'b00, src0_v};
        iss_dst   = dst;
        iss_dst_v = dst_v;
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b0;
        ra     = '0;
        pc_val = 32'h108;
        idle_inputs();

        // ra packing {p2,p1,p0}; expected rd packing {p2,p1,p0}.
        vecs[0] = '{1'b1, 4'd1,  32'hDEAD, 1'b0, 4'd0,  32'h0,    12'hF21,
                    {32'h108, 32'h0, 32'hDEAD}, {32'h108, 32'h0, 32'h0}};
        vecs[1] = '{1'b1, 4'd2,  32'h11,   1'b1, 4'd2,  32'h22,   12'h312,
                    {32'h0, 32'hDEAD, 32'h22}, {32'h0, 32'hDEAD, 32'h0}};
        vecs[2] = '{1'b1, 4'd3,  32'h33,   1'b1, 4'd15, 32'h77,   12'hF32,
                    {32'h108, 32'h33, 32'h22}, {32'h108, 32'h0, 32'h22}};
        vecs[3] = '{1'b1, 4'd15, 32'hFF,   1'b0, 4'd0,  32'h0,    12'h03F,
                    {32'h0, 32'h33, 32'h108}, {32'h0, 32'h33, 32'h108}};
        vecs[4] = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0,  32'h0,    12'h321,
                    {32'h33, 32'h22, 32'hDEAD}, {32'h33, 32'h22, 32'hDEAD}};
        vecs[5] = '{1'b1, 4'd0,  32'hA5A5, 1'b1, 4'd1,  32'h5A5A, 12'hE10,
                    {32'h0, 32'h5A5A, 32'hA5A5}, {32'h0, 32'hDEAD, 32'h0}};
        vecs[6] = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0,  32'h0,    12'hF10,
                    {32'h108, 32'h5A5A, 32'hA5A5}, {32'h108, 32'h5A5A, 32'hA5A5}};

        tick();
        tick();
        reset = 1'b1;
        settle();
        check("init_busy_byp", busy_byp, 16'h0);
        check("init_stall_idle", {stall_byp, stall_nb}, 2'b00);

        // Table-driven read/write/bypass vectors.
        for (int i = 0; i < 7; i++) begin
            we_a = vecs[i].we_a; wa_a = vecs[i].wa_a; wd_a = vecs[i].wd_a;
            we_b = vecs[i].we_b; wa_b = vecs[i].wa_b; wd_b = vecs[i].wd_b;
            ra   = vecs[i].ra;
            settle();
            check($sformatf("vec%0d_rd_byp", i), rd_byp, vecs[i].exp_byp);
            check($sformatf("vec%0d_rd_nb", i),  rd_nb,  vecs[i].exp_nb);
            tick();
        end
        idle_inputs();

        // Reset for one edge with r0..r3 holding data.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ra = 12'h321;
        settle();
        check("rst_rd_byp", rd_byp, 96'h0);
        check("rst_rd_nb", rd_nb, 96'h0);
        check("rst_busy", {busy_byp, busy_nb}, 32'h0);
        ra = 12'h00F;
        settle();
        check("rst_pc_read", rd_byp, {32'h0, 32'h0, 32'h108});

        // RAW on r5: stall until the load writeback lands.
        tick();
        issue(4'd0, 1'b0, 4'd5, 1'b1);
        settle();
        check("raw_issue_dst", {stall_byp, stall_nb}, 2'b00);
        tick();
        idle_inputs();
        check("raw_busy_set", {busy_byp, busy_nb}, {16'h0020, 16'h0020});
        issue(4'd5, 1'b1, 4'd0, 1'b0);
        settle();
        check("raw_stall_1", {stall_byp, stall_nb}, 2'b11);
        tick();
        settle();
        check("raw_stall_2", {stall_byp, stall_nb}, 2'b11);
        we_b = 1'b1; wa_b = 4'd5; wd_b = 32'h55;
        settle();
        check("raw_land_stall", {stall_byp, stall_nb}, 2'b01);
        tick();
        we_b = 1'b0;
        check("raw_busy_clr", {busy_byp, busy_nb}, 32'h0);
        ra = 12'h005;
        settle();
        check("raw_after_stall", {stall_byp, stall_nb}, 2'b00);
        check("raw_r5_data", rd_nb[31:0], 32'h55);
        tick();
        idle_inputs();

        // WAW on r5: blocked without a clear, accepted when port A lands.
        issue(4'd0, 1'b0, 4'd5, 1'b1);
        tick();
        check("waw_busy_set", busy_byp, 16'h0020);
        settle();
        check("waw_stall", {stall_byp, stall_nb}, 2'b11);
        tick();
        check("waw_busy_hold", busy_nb, 16'h0020);
        we_a = 1'b1; wa_a = 4'd5; wd_a = 32'h66;
        settle();
        check("waw_clr_accept", {stall_byp, stall_nb}, 2'b00);
        tick();
        idle_inputs();
        check("waw_set_wins", {busy_byp, busy_nb}, {16'h0020, 16'h0020});
        we_a = 1'b1; wa_a = 4'd5; wd_a = 32'h67;
        tick();
        idle_inputs();
        check("waw_final_clr", {busy_byp, busy_nb}, 32'h0);

        // PC index as destination and source: never busy, never stalls.
        issue(4'd15, 1'b1, 4'd15, 1'b1);
        settle();
        check("pc_issue_stall", {stall_byp, stall_nb}, 2'b00);
        tick();
        idle_inputs();
        check("pc_busy", {busy_byp, busy_nb}, 32'h0);

        // Build busy = 0x0036, check a second-port source hazard, then reset.
        issue(4'd0, 1'b0, 4'd1, 1'b1); tick();
        issue(4'd0, 1'b0, 4'd2, 1'b1); tick();
        issue(4'd0, 1'b0, 4'd4, 1'b1); tick();
        issue(4'd0, 1'b0, 4'd5, 1'b1); tick();
        idle_inputs();
        check("busy_0036", {busy_byp, busy_nb}, {16'h0036, 16'h0036});
        iss_valid = 1'b1; iss_src = 12'h040; iss_src_v = 3'b010;
        settle();
        check("src1_haz", {stall_byp, stall_nb}, 2'b11);
        iss_src_v = 3'b000;
        settle();
        check("src_invalid", {stall_byp, stall_nb}, 2'b00);
        idle_inputs();
        reset = 1'b0;
        we_a = 1'b1; wa_a = 4'd1; wd_a = 32'h99;
        issue(4'd0, 1'b0, 4'd3, 1'b1);
        tick();
        reset = 1'b1;
        idle_inputs();
        ra = 12'h001;
        settle();
        check("rst_busy_clr", {busy_byp, busy_nb}, 32'h0);
        check("rst_drop_wb", {rd_byp[31:0], rd_nb[31:0]}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
